// File: rtl/gcd_req_m.sv
// Requester for an nstart/enable/valid GCD core. It accepts operand pairs on a
// ready/valid port, sequences the core, and returns the result on a ready/valid port.
module gcd_req_m #(
  parameter int unsigned W       = 6,
  parameter int unsigned TIMEOUT = 127,
  parameter int unsigned CNT_W   = 7
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [W-1:0] req_a,
  input  logic [W-1:0] req_b,
  output logic         core_nstart,
  output logic         core_enable,
  output logic [W-1:0] core_ain,
  output logic [W-1:0] core_bin,
  input  logic [W-1:0] core_out,
  input  logic         core_valid,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [W-1:0] rsp_gcd,
  output logic         rsp_err,
  output logic         busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    RESP = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;

  // Sequencer: the operand latches, the result and the run counter are all held here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      rsp_gcd  <= '0;
      rsp_err  <= 1'b0;
      core_ain <= '0;
      core_bin <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            core_ain <= req_a;
            core_bin <= req_b;
            if (req_a == '0 && req_b == '0) begin
              rsp_gcd <= '0;
              rsp_err <= 1'b1;
              state   <= RESP;
            end else if (req_a == '0 || req_b == '0) begin
              // gcd(x, 0) = x; the core is left untouched
              rsp_gcd <= req_a | req_b;
              rsp_err <= 1'b0;
              state   <= RESP;
            end else begin
              cnt   <= '0;
              state <= LOAD;
            end
          end
        end
        LOAD: state <= RUN;
        RUN: begin
          // A completion from the core takes priority over a timeout in the same cycle
          if (core_valid) begin
            rsp_gcd <= core_out;
            rsp_err <= 1'b0;
            state   <= RESP;
          end else if (cnt == CNT_LAST) begin
            rsp_gcd <= '0;
            rsp_err <= 1'b1;
            state   <= RESP;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        RESP: begin
          if (rsp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Port decodes of the registered state only; there is no path from an input to an output.
  assign req_ready   = (state == IDLE);
  assign busy        = (state != IDLE);
  assign core_nstart = (state != LOAD);
  assign core_enable = (state == RUN);
  assign rsp_valid   = (state == RESP);

endmodule

// File: tb/tb_gcd_req_m.sv
// Testbench for gcd_req_m. A behavioural GCD core drives the core port, and a
// scoreboard compares every response handshake with a reference GCD model.
module tb_gcd_req_m;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid, req_ready;
  logic [5:0] req_a, req_b;
  logic       core_nstart, core_enable;
  logic [5:0] core_ain, core_bin, core_out;
  logic       core_valid;
  logic       rsp_valid, rsp_ready;
  logic [5:0] rsp_gcd;
  logic       rsp_err, busy;

  // Second instance with a short timeout and a core that never finishes
  logic       t_req_valid, t_req_ready;
  logic [5:0] t_req_a, t_req_b;
  logic       t_core_nstart, t_core_enable;
  logic [5:0] t_core_ain, t_core_bin;
  logic       t_rsp_valid, t_rsp_ready;
  logic [5:0] t_rsp_gcd;
  logic       t_rsp_err, t_busy;

  always #5 clk = ~clk;

  gcd_req_m dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .core_nstart(core_nstart),
    .core_enable(core_enable), .core_ain(core_ain), .core_bin(core_bin),
    .core_out(core_out), .core_valid(core_valid), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_gcd(rsp_gcd), .rsp_err(rsp_err), .busy(busy)
  );

  gcd_req_m #(.W(6), .TIMEOUT(4), .CNT_W(7)) dut_t (
    .clk(clk), .rst(rst), .req_valid(t_req_valid), .req_ready(t_req_ready),
    .req_a(t_req_a), .req_b(t_req_b), .core_nstart(t_core_nstart),
    .core_enable(t_core_enable), .core_ain(t_core_ain), .core_bin(t_core_bin),
    .core_out(6'd0), .core_valid(1'b0), .rsp_valid(t_rsp_valid),
    .rsp_ready(t_rsp_ready), .rsp_gcd(t_rsp_gcd), .rsp_err(t_rsp_err), .busy(t_busy)
  );

  typedef struct packed {
    logic [5:0] g;
    logic       e;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   nload  = 0;
  bit   done   = 1'b0;

  // Behavioural core: one subtraction per enabled cycle, plus an optional extra delay
  // before valid rises. A core that never finishes is also available.
  logic [5:0] ca = '0, cb = '0, cout = '0;
  logic       cval = 1'b0, cstuck = 1'b0;
  int         cwait = 0;
  int         cfg_dly = 0;
  bit         cfg_stuck = 1'b0;

  assign core_out   = cout;
  assign core_valid = cval;

  always @(posedge clk) begin
    if (!core_nstart) begin
      ca     <= core_ain;
      cb     <= core_bin;
      cval   <= 1'b0;
      cwait  <= cfg_dly;
      cstuck <= cfg_stuck;
    end else if (core_enable && !cval && !cstuck) begin
      if (ca == cb) begin
        if (cwait == 0) begin
          cval <= 1'b1;
          cout <= ca;
        end else begin
          cwait <= cwait - 1;
        end
      end else if (ca > cb) begin
        ca <= ca - cb;
      end else begin
        cb <= cb - ca;
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic exp_t ref_model(input int a, input int b, input bit stuck);
    exp_t r;
    int x, y, t;
    if (a == 0 && b == 0) begin
      r.g = 6'd0; r.e = 1'b1;
    end else if (a == 0 || b == 0) begin
      r.g = 6'(a + b); r.e = 1'b0;
    end else if (stuck) begin
      r.g = 6'd0; r.e = 1'b1;
    end else begin
      x = a; y = b;
      while (y != 0) begin
        t = x % y; x = y; y = t;
      end
      r.g = 6'(x); r.e = 1'b0;
    end
    return r;
  endfunction

  // Monitor: checks every response handshake against the head of the queue.
  always @(negedge clk) begin
    if (!rst && !core_nstart) nload++;
    if (!rst && rsp_valid && rsp_ready) begin
      chk("rsp_pending", exp_q.size(), 1);
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        chk("rsp_gcd", int'(rsp_gcd), int'(e.g));
        chk("rsp_err", int'(rsp_err), int'(e.e));
      end
    end
  end

  // Presents a request, waits for acceptance and returns one time step after the accept edge.
  task automatic send(input int a, input int b, input bit stuck, input int dly, input bit hold);
    int n;
    req_a = 6'(a); req_b = 6'(b); req_valid = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (req_ready) break;
      n++;
      if (n > 2000) begin
        chk("accept_timeout", n, 0);
        req_valid = 1'b0;
        return;
      end
    end
    cfg_stuck = stuck;
    cfg_dly   = dly;
    exp_q.push_back(ref_model(a, b, stuck));
    @(posedge clk); #1;
    if (!hold) req_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (exp_q.size() != 0 || busy) begin
      @(negedge clk);
      n++;
      if (n > 2000) begin
        chk("drain_timeout", n, 0);
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int k, nrun, l0;
    rst = 1'b1; req_valid = 1'b0; req_a = '0; req_b = '0; rsp_ready = 1'b1;
    t_req_valid = 1'b0; t_req_a = '0; t_req_b = '0; t_rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_rsp_valid", int'(rsp_valid), 0);
    chk("rst_nstart", int'(core_nstart), 1);
    chk("rst_enable", int'(core_enable), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_req_ready", int'(req_ready), 1);
    chk("rst_gcd", int'(rsp_gcd), 0);
    chk("rst_err", int'(rsp_err), 0);
    chk("rst_ain", int'(core_ain), 0);
    chk("rst_bin", int'(core_bin), 0);
    @(posedge clk); #1 rst = 1'b0;

    // Latency with the fast core: LOAD in cycle 1, a single-cycle response after edge 5
    send(12, 8, 1'b0, 0, 1'b0);
    k = 0;
    forever begin
      @(negedge clk);
      k++;
      if (k == 1) chk("t1_load_nstart", int'(core_nstart), 0);
      if (rsp_valid || k > 50) break;
    end
    chk("t1_latency_edges", k - 1, 5);
    @(negedge clk);
    chk("t1_rsp_one_cycle", int'(rsp_valid), 0);
    wait_done();

    // Zero operands are answered locally, without loading the core
    l0 = nload;
    send(0, 9, 1'b0, 0, 1'b0);
    @(negedge clk);
    chk("t2_resp_next_edge", int'(rsp_valid), 1);
    wait_done();
    send(0, 0, 1'b0, 0, 1'b0);
    wait_done();
    send(33, 0, 1'b0, 0, 1'b0);
    wait_done();
    chk("t2_no_load", nload - l0, 0);

    // Timeout with TIMEOUT=4: exactly four RUN cycles, then an error response
    t_req_a = 6'd5; t_req_b = 6'd3; t_req_valid = 1'b1;
    @(posedge clk); #1 t_req_valid = 1'b0;
    nrun = 0; k = 0;
    forever begin
      @(negedge clk);
      k++;
      if (t_core_enable) nrun++;
      if (t_rsp_valid || k > 50) break;
    end
    chk("t3_run_cycles", nrun, 4);
    chk("t3_rsp_valid", int'(t_rsp_valid), 1);
    chk("t3_err", int'(t_rsp_err), 1);
    chk("t3_gcd", int'(t_rsp_gcd), 0);
    @(posedge clk); #1;
    // Default timeout with a core that never finishes
    send(5, 3, 1'b1, 0, 1'b0);
    wait_done();

    // Back-pressure: the response holds and the core stays frozen
    rsp_ready = 1'b0;
    send(63, 21, 1'b0, 0, 1'b0);
    k = 0;
    while (!rsp_valid && k < 200) begin
      @(negedge clk);
      k++;
    end
    repeat (10) begin
      @(negedge clk);
      chk("t4_hold_valid", int'(rsp_valid), 1);
      chk("t4_hold_gcd", int'(rsp_gcd), 21);
      chk("t4_hold_enable", int'(core_enable), 0);
      chk("t4_hold_req_ready", int'(req_ready), 0);
    end
    @(posedge clk); #1 rsp_ready = 1'b1;
    wait_done();
    send(6, 4, 1'b0, 0, 1'b0);
    wait_done();

    // Reset during the second RUN cycle discards the result
    send(40, 24, 1'b0, 0, 1'b0);
    @(posedge clk);
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    chk("t5_in_run", int'(core_enable), 1);
    @(posedge clk); #1 rst = 1'b0;
    void'(exp_q.pop_back());
    @(negedge clk);
    chk("t5_idle_ready", int'(req_ready), 1);
    chk("t5_idle_busy", int'(busy), 0);
    chk("t5_no_rsp", int'(rsp_valid), 0);
    repeat (20) @(negedge clk);
    @(posedge clk); #1;
    send(9, 6, 1'b0, 0, 1'b0);
    wait_done();

    // Back-to-back requests with req_valid held high
    send(35, 14, 1'b0, 0, 1'b1);
    send(17, 5, 1'b0, 0, 1'b0);
    wait_done();

    // Random operands, core delays and consumer back-pressure
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          int a, b, dly;
          bit stuck;
          a = ($urandom % 8 == 0) ? 0 : int'($urandom_range(1, 63));
          b = ($urandom % 8 == 0) ? 0 : int'($urandom_range(1, 63));
          stuck = ($urandom % 12 == 0);
          dly = int'($urandom_range(0, 15));
          send(a, b, stuck, dly, ($urandom % 2 == 0));
        end
        req_valid = 1'b0;
        wait_done();
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          rsp_ready = ($urandom % 4 != 0);
        end
      end
    join
    rsp_ready = 1'b1;
    chk("final_queue_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
